// File: rtl/breadboard_inverse_scan.sv
// Sequential inverse of the Breadboard 4-in/10-out function: finds the first code that reproduces resp and counts matches.
// Latency: start accepted at edge 0, done pulses after edge LAST_CODE+1 (or after edge k+1 with BREADBOARD_EARLY_EXIT_EN, k = first match).
// Backpressure: none; start is ignored while busy, results hold until the next accepted start.
module breadboard_inverse_scan #(
  parameter int LAST_CODE = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] resp,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [3:0] wxyz,
  output logic [4:0] match_cnt
);

  localparam logic [3:0] LAST = 4'(LAST_CODE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [9:0] resp_q;
  logic       found_q;
  logic [3:0] wxyz_q;
  logic [4:0] match_cnt_q;
  logic [9:0] cand_resp;
  logic       hit;
  logic       w, x, y, z;

  // Evaluate the ten Breadboard functions on the current candidate code
  always_comb begin
    w = cnt_q[3];
    x = cnt_q[2];
    y = cnt_q[1];
    z = cnt_q[0];
    cand_resp    = '0;
    cand_resp[0] = (w & x) | (w & z) | (x & y) | (y & z);
    cand_resp[1] = (w & x) | (x & z) | (y & z);
    cand_resp[2] = (w & y & z) | (w & x & z) | (x & y & z) | (w & x & y);
    cand_resp[3] = (w & z) | (x & y);
    cand_resp[4] = y & z;
    cand_resp[5] = (~w & ~x) | (~y & ~z);
    cand_resp[6] = (~w & ~x & y) | (~w & ~y & z) | (x & ~y & z) | (w & ~x & ~y & ~z);
    cand_resp[7] = (~w & ~x & y & z) | (~w & x & ~y & z) | (~w & x & y & ~z)
                 | (w & x & ~y & ~z) | (w & ~x & ~y & z) | (w & ~x & y & ~z);
    cand_resp[8] = y & z;
    cand_resp[9] = (~w & ~x & ~y & z) | (~w & ~x & y & ~z) | (~w & x & ~y & ~z)
                 | (~w & x & y & z)   | (w & x & ~y & z)   | (w & x & y & ~z)
                 | (w & ~x & ~y & ~z) | (w & ~x & y & z);
    hit = (cand_resp == resp_q);
  end

  // Next-state selection: scan ends at the last code, or at the first hit when early exit is built in
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: begin
`ifdef BREADBOARD_EARLY_EXIT_EN
        if ((hit && !found_q) || (cnt_q == LAST)) state_d = DONE;
`else
        if (cnt_q == LAST) state_d = DONE;
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture on start, then step the candidate and accumulate match results during the scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      resp_q      <= '0;
      found_q     <= 1'b0;
      wxyz_q      <= '0;
      match_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            resp_q      <= resp;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            wxyz_q      <= '0;
            match_cnt_q <= '0;
          end
        end
        SCAN: begin
          if (hit) match_cnt_q <= match_cnt_q + 5'd1;
          if (hit && !found_q) begin
            found_q <= 1'b1;
            wxyz_q  <= cnt_q;
          end
          // Hold at the last code so the counter never wraps
          if (cnt_q != LAST) cnt_q <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign found     = found_q;
  assign wxyz      = wxyz_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_breadboard_inverse_scan.sv
module tb_breadboard_inverse_scan;

  localparam int LAST = 15;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] resp;
  logic       busy;
  logic       done;
  logic       found;
  logic [3:0] wxyz;
  logic [4:0] match_cnt;

  int checks;
  int failures;

  breadboard_inverse_scan #(.LAST_CODE(LAST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .wxyz      (wxyz),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Breadboard function from its truth-table properties
  function automatic logic [9:0] bb(input int c);
    logic w, x, y, z;
    int n;
    logic [9:0] r;
    w = c[3]; x = c[2]; y = c[1]; z = c[0];
    n = int'(w) + int'(x) + int'(y) + int'(z);
    r = '0;
    r[0] = (w && x) || (w && z) || (x && y) || (y && z);
    r[1] = (w && x) || (x && z) || (y && z);
    r[2] = (n >= 3);
    r[3] = (w && z) || (x && y);
    r[4] = y && z;
    r[5] = (!w && !x) || (!y && !z);
    r[6] = (c == 1) || (c == 2) || (c == 3) || (c == 5) || (c == 8) || (c == 13);
    r[7] = (n == 2);
    r[8] = y && z;
    r[9] = (n % 2 == 1);
    return r;
  endfunction

  // Expected scan outcome: first match, match count and the edge at which done appears
  task automatic model_scan(input logic [9:0] r, output logic f, output logic [3:0] first,
                            output int cnt, output int done_edge);
    f = 1'b0; first = '0; cnt = 0; done_edge = LAST + 1;
    for (int c = 0; c <= LAST; c++) begin
      if (bb(c) == r) begin
        cnt++;
        if (!f) begin
          f = 1'b1;
          first = 4'(c);
`ifdef BREADBOARD_EARLY_EXIT_EN
          done_edge = c + 1;
          break;
`endif
        end
      end
    end
  endtask

  task automatic run_scan(input string tag, input logic [9:0] r, input bit pulse_mid,
                          input logic [9:0] r2);
    logic f_e;
    logic [3:0] w_e;
    int cnt_e, edge_e, n;
    bit seen;
    model_scan(r, f_e, w_e, cnt_e, edge_e);
    @(negedge clk);
    start = 1'b1;
    resp  = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    resp  = 10'($urandom);
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (pulse_mid && n == 3) begin
        start = 1'b1;
        resp  = r2;
      end else if (pulse_mid && n == 4) begin
        start = 1'b0;
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    chk({tag, "_done_edge"}, n, edge_e);
    chk({tag, "_found"}, found, f_e);
    chk({tag, "_wxyz"}, wxyz, w_e);
    chk({tag, "_cnt"}, match_cnt, cnt_e);
    if (f_e) chk({tag, "_roundtrip"}, bb(int'(wxyz)), r);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold_cnt"}, match_cnt, cnt_e);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    resp  = '0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_wxyz", wxyz, 0);
    chk("rst_cnt", match_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the response table
    run_scan("code0", 10'h020, 0, '0);
    run_scan("c7_c11", 10'h31F, 0, '0);
    run_scan("nomatch", 10'h3FF, 0, '0);
    run_scan("ignore_start", 10'h11F, 1, 10'h020);
    chk("ignore_start_wxyz", wxyz, 4'hF);

    // Reset in the middle of a scan
    @(negedge clk);
    start = 1'b1;
    resp  = 10'h020;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_found", found, 0);
    chk("mid_rst_wxyz", wxyz, 0);
    chk("mid_rst_cnt", match_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (done) pulses++;
      end
      chk("mid_rst_no_done", pulses, 0);
    end

    // Every code's own response
    for (int c = 0; c <= LAST; c++) run_scan("sweep", bb(c), 0, '0);

    // Random responses, biased toward ones that actually occur
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(1, 0) == 1) run_scan("rand_hit", bb(int'($urandom_range(LAST, 0))), 0, '0);
      else                           run_scan("rand_any", 10'($urandom), 0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
